// File: rtl/regfile_writeback_queue.sv
// ----------------------------------------------------------------------------
// regfile_writeback_queue
//
// Writeback buffer in front of the register file write port. ALU and load
// results are queued in order in a small FIFO (ALU first when both arrive in
// the same cycle). One entry per cycle drains into a registered output stage
// that drives the register file write port. Decode can forward from any
// write that has not yet reached the register file.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   Alu_valid/ready/reg/data      ALU result handshake
//   Ld_valid/ready/reg/data       load result handshake
//   Write_enable/reg/data         registered register file write port
//   Read_reg1/2                   decode source registers
//   Fwd_hit1/2, Fwd_data1/2       forwarding result per read port
//   Count, Full, Empty            FIFO occupancy (output stage excluded)
// ----------------------------------------------------------------------------
module regfile_writeback_queue #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Alu_valid,
    output logic                       Alu_ready,
    input  logic [ADDR_BITS-1:0]       Alu_reg,
    input  logic [DATA_BITS-1:0]       Alu_data,
    input  logic                       Ld_valid,
    output logic                       Ld_ready,
    input  logic [ADDR_BITS-1:0]       Ld_reg,
    input  logic [DATA_BITS-1:0]       Ld_data,
    output logic                       Write_enable,
    output logic [ADDR_BITS-1:0]       Write_reg,
    output logic [DATA_BITS-1:0]       Write_data,
    input  logic [ADDR_BITS-1:0]       Read_reg1,
    input  logic [ADDR_BITS-1:0]       Read_reg2,
    output logic                       Fwd_hit1,
    output logic [DATA_BITS-1:0]       Fwd_data1,
    output logic                       Fwd_hit2,
    output logic [DATA_BITS-1:0]       Fwd_data2,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_BITS-1:0] q_reg  [DEPTH];
    logic [DATA_BITS-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]     q_vld;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     wr_ptr_ld;

    logic [CNT_W-1:0]     free;
    logic                 alu_push;
    logic                 ld_push;
    logic                 pop;

    // Free space comes from registered Count only; a same-cycle pop does not
    // make room, which keeps ready independent of the drain path.
    assign free      = CNT_W'(DEPTH) - Count;
    assign Alu_ready = (free != '0);
    assign alu_push  = Alu_valid & Alu_ready & (Alu_reg != '0);
    assign Ld_ready  = (free >= (CNT_W'(1) + CNT_W'(alu_push)));
    // Register-0 writes complete the handshake but are dropped here.
    assign ld_push   = Ld_valid & Ld_ready & (Ld_reg != '0);
    assign pop       = (Count != '0);

    // The load entry lands behind the ALU entry when both push together.
    assign wr_ptr_ld = wr_ptr + PTR_W'(alu_push);

    assign Full  = (Count == CNT_W'(DEPTH));
    assign Empty = (Count == '0);

    // Control state and the output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            Count        <= '0;
            q_vld        <= '0;
            Write_enable <= 1'b0;
            Write_reg    <= '0;
            Write_data   <= '0;
        end else begin
            if (pop) begin
                Write_enable  <= 1'b1;
                Write_reg     <= q_reg[rd_ptr];
                Write_data    <= q_data[rd_ptr];
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end else begin
                Write_enable <= 1'b0;
            end
            // A push slot never equals the head slot while popping, since a
            // push needs free space and a pop needs a non-empty queue.
            if (alu_push) begin
                q_vld[wr_ptr] <= 1'b1;
            end
            if (ld_push) begin
                q_vld[wr_ptr_ld] <= 1'b1;
            end
            wr_ptr <= wr_ptr + PTR_W'(alu_push) + PTR_W'(ld_push);
            Count  <= Count + CNT_W'(alu_push) + CNT_W'(ld_push) - CNT_W'(pop);
        end
    end

    // Payload storage; validity is tracked by q_vld so no reset is needed.
    always_ff @(posedge CLK) begin
        if (alu_push) begin
            q_reg[wr_ptr]  <= Alu_reg;
            q_data[wr_ptr] <= Alu_data;
        end
        if (ld_push) begin
            q_reg[wr_ptr_ld]  <= Ld_reg;
            q_data[wr_ptr_ld] <= Ld_data;
        end
    end

    // Forwarding search, walked oldest to youngest so the last match wins:
    // output stage first, then FIFO entries from the head onward.
    function automatic logic [DATA_BITS:0] fwd_lookup(input logic [ADDR_BITS-1:0] ra);
        logic                 hit;
        logic [DATA_BITS-1:0] data;
        logic [PTR_W-1:0]     idx;
        hit  = 1'b0;
        data = '0;
        if (ra != '0) begin
            if (Write_enable && (Write_reg == ra)) begin
                hit  = 1'b1;
                data = Write_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if (q_vld[idx] && (q_reg[idx] == ra)) begin
                    hit  = 1'b1;
                    data = q_data[idx];
                end
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {Fwd_hit1, Fwd_data1} = fwd_lookup(Read_reg1);
        {Fwd_hit2, Fwd_data2} = fwd_lookup(Read_reg2);
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1, read_reg2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        full, empty;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_writeback_queue #(.ADDR_BITS(5), .DATA_BITS(32), .DEPTH(4)) dut (
        .CLK(clk), .RST(rst),
        .Alu_valid(alu_valid), .Alu_ready(alu_ready), .Alu_reg(alu_reg), .Alu_data(alu_data),
        .Ld_valid(ld_valid), .Ld_ready(ld_ready), .Ld_reg(ld_reg), .Ld_data(ld_data),
        .Write_enable(write_enable), .Write_reg(write_reg), .Write_data(write_data),
        .Read_reg1(read_reg1), .Read_reg2(read_reg2),
        .Fwd_hit1(fwd_hit1), .Fwd_data1(fwd_data1),
        .Fwd_hit2(fwd_hit2), .Fwd_data2(fwd_data2),
        .Count(count), .Full(full), .Empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
        logic [2:0]  cnt;
        logic        ardy;
        logic        lrdy;
    } vec_t;

    localparam int NVEC = 34;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        alu_valid = v.av;
        alu_reg   = v.ar;
        alu_data  = v.ad;
        ld_valid  = v.lv;
        ld_reg    = v.lr;
        ld_data   = v.ld;
        read_reg1 = v.r1;
        read_reg2 = v.r2;
    endtask

    initial begin
        // Inputs are applied after the falling edge; each row's expectations
        // describe the state left by earlier rising edges plus this row's
        // combinational inputs.
        for (int i = 0; i < 5; i++)
            tbl[i] = '{0,0,0,0,0,0,0,3,5, 0,0,0,0,0,0,0,0,1,1};
        // Single ALU push, two-edge latency, forwarding from FIFO then output stage
        tbl[5]  = '{0,1,3,'hAA,0,0,0,3,5, 0,0,0,0,0,0,0,0,1,1};
        tbl[6]  = '{0,0,0,0,0,0,0,3,5, 0,0,0,1,'hAA,0,0,1,1,1};
        tbl[7]  = '{0,0,0,0,0,0,0,3,5, 1,3,'hAA,1,'hAA,0,0,0,1,1};
        tbl[8]  = '{0,0,0,0,0,0,0,3,5, 0,3,'hAA,0,0,0,0,0,1,1};
        // Same-cycle ALU/load to reg 5: ALU older, load youngest
        tbl[9]  = '{0,1,5,'h11,1,5,'h22,5,3, 0,3,'hAA,0,0,0,0,0,1,1};
        tbl[10] = '{0,0,0,0,0,0,0,5,3, 0,3,'hAA,1,'h22,0,0,2,1,1};
        tbl[11] = '{0,0,0,0,0,0,0,5,3, 1,5,'h11,1,'h22,0,0,1,1,1};
        tbl[12] = '{0,0,0,0,0,0,0,5,3, 1,5,'h22,1,'h22,0,0,0,1,1};
        tbl[13] = '{0,0,0,0,0,0,0,5,3, 0,5,'h22,0,0,0,0,0,1,1};
        // Back-to-back dual pushes: occupancy settles at 3, load backpressured
        tbl[14] = '{0,1,1,'h101,1,2,'h102,1,2, 0,5,'h22,0,0,0,0,0,1,1};
        tbl[15] = '{0,1,3,'h103,1,4,'h104,1,4, 0,5,'h22,1,'h101,0,0,2,1,1};
        tbl[16] = '{0,1,6,'h106,1,7,'h107,1,4, 1,1,'h101,1,'h101,1,'h104,3,1,0};
        tbl[17] = '{0,1,7,'h207,1,8,'h108,6,2, 1,2,'h102,1,'h106,1,'h102,3,1,0};
        tbl[18] = '{0,0,0,0,1,8,'h108,7,4, 1,3,'h103,1,'h207,1,'h104,3,1,1};
        tbl[19] = '{0,0,0,0,0,0,0,8,3, 1,4,'h104,1,'h108,0,0,3,1,1};
        tbl[20] = '{0,0,0,0,0,0,0,6,8, 1,6,'h106,1,'h106,1,'h108,2,1,1};
        tbl[21] = '{0,0,0,0,0,0,0,6,8, 1,7,'h207,0,0,1,'h108,1,1,1};
        tbl[22] = '{0,0,0,0,0,0,0,6,8, 1,8,'h108,0,0,1,'h108,0,1,1};
        tbl[23] = '{0,0,0,0,0,0,0,6,8, 0,8,'h108,0,0,0,0,0,1,1};
        // ALU write to reg 0 with a load to reg 7
        tbl[24] = '{0,1,0,'h55,1,7,'h77,0,7, 0,8,'h108,0,0,0,0,0,1,1};
        tbl[25] = '{0,0,0,0,0,0,0,0,7, 0,8,'h108,0,0,1,'h77,1,1,1};
        tbl[26] = '{0,0,0,0,0,0,0,0,7, 1,7,'h77,0,0,1,'h77,0,1,1};
        tbl[27] = '{0,0,0,0,0,0,0,0,7, 0,7,'h77,0,0,0,0,0,1,1};
        // Reset with Count=3 and an active write drops everything
        tbl[28] = '{0,1,9,'h9,1,10,'hA,9,10, 0,7,'h77,0,0,0,0,0,1,1};
        tbl[29] = '{0,1,11,'hB,1,12,'hC,9,12, 0,7,'h77,1,'h9,0,0,2,1,1};
        tbl[30] = '{1,1,13,'hD,0,0,0,9,11, 1,9,'h9,1,'h9,1,'hB,3,1,0};
        for (int i = 31; i < NVEC; i++)
            tbl[i] = '{0,0,0,0,0,0,0,9,11, 0,0,0,0,0,0,0,0,1,1};

        rst = 1'b1;
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        ld_valid = 0; ld_reg = 0; ld_data = 0;
        read_reg1 = 0; read_reg2 = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d Write_enable", i), 32'(write_enable), 32'(tbl[i].we));
            check($sformatf("v%0d Write_reg", i),    32'(write_reg),    32'(tbl[i].wr));
            check($sformatf("v%0d Write_data", i),   write_data,        tbl[i].wd);
            check($sformatf("v%0d Fwd_hit1", i),     32'(fwd_hit1),     32'(tbl[i].h1));
            check($sformatf("v%0d Fwd_data1", i),    fwd_data1,         tbl[i].d1);
            check($sformatf("v%0d Fwd_hit2", i),     32'(fwd_hit2),     32'(tbl[i].h2));
            check($sformatf("v%0d Fwd_data2", i),    fwd_data2,         tbl[i].d2);
            check($sformatf("v%0d Count", i),        32'(count),        32'(tbl[i].cnt));
            check($sformatf("v%0d Full", i),         32'(full),         32'(tbl[i].cnt == 3'd4));
            check($sformatf("v%0d Empty", i),        32'(empty),        32'(tbl[i].cnt == 3'd0));
            check($sformatf("v%0d Alu_ready", i),    32'(alu_ready),    32'(tbl[i].ardy));
            check($sformatf("v%0d Ld_ready", i),     32'(ld_ready),     32'(tbl[i].lrdy));
        end

        // Sustained throughput: one ALU push per cycle drains one write per cycle.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            ld_valid  = 1'b0;
            alu_valid = (c < 6);
            alu_reg   = 5'(c + 1);
            alu_data  = 32'h1000 + 32'(c);
            read_reg1 = 5'd0;
            read_reg2 = 5'd0;
            #1;
            check($sformatf("tput%0d Write_enable", c), 32'(write_enable), 32'(c >= 2 && c <= 7));
            check($sformatf("tput%0d Count", c), 32'(count), 32'(c >= 1 && c <= 6));
            if (c >= 2 && c <= 7) begin
                check($sformatf("tput%0d Write_reg", c), 32'(write_reg), 32'(c - 1));
                check($sformatf("tput%0d Write_data", c), write_data, 32'h1000 + 32'(c - 2));
            end
        end

        // Reset in the same cycle as a push: the push is discarded.
        @(negedge clk);
        rst = 1'b1; alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'h44; read_reg1 = 5'd4;
        @(negedge clk);
        rst = 1'b0; alu_valid = 1'b0;
        #1;
        check("rstpush Count", 32'(count), 32'd0);
        check("rstpush Fwd_hit1", 32'(fwd_hit1), 32'd0);
        @(negedge clk);
        #1;
        check("rstpush Write_enable", 32'(write_enable), 32'd0);
        check("rstpush Empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
